// File: rtl/serial_byte_loader.sv
// Serial-to-parallel word loader with a one-entry valid/ready output buffer.
// Optional even-parity bit per word when PARITY_CHECK_EN is defined.
module serial_byte_loader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sync,
    input  logic             out_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] d_out,
    output logic             out_valid,
    output logic             busy,
`ifdef PARITY_CHECK_EN
    output logic             par_err,
`endif
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef PARITY_CHECK_EN
        ,
        PAR   = 2'd2
`endif
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [WIDTH-1:0]   shreg, shreg_nxt;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   word;
    logic               word_done;
    logic               par_fail;
    logic               buf_free;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (MSB_FIRST)
            return {cur[WIDTH-2:0], b};
        else
            return {b, cur[WIDTH-1:1]};
    endfunction

    // A sync edge restarts from an empty register, so the new word never mixes with stale bits.
    assign shifted  = shift_in(sync ? '0 : shreg, sin);
    assign buf_free = !out_valid || out_ready;
    assign busy     = (count != '0);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        shreg_nxt = shreg;
        word      = shifted;
        word_done = 1'b0;
        par_fail  = 1'b0;
        if (sync) begin
            if (sin_valid) begin
                state_nxt = SHIFT;
                count_nxt = CNT_W'(1);
                shreg_nxt = shifted;
            end else begin
                state_nxt = IDLE;
                count_nxt = '0;
                shreg_nxt = '0;
            end
        end else if (sin_valid) begin
            case (state)
                IDLE: begin
                    state_nxt = SHIFT;
                    count_nxt = CNT_W'(1);
                    shreg_nxt = shifted;
                end
                SHIFT: begin
                    if (count == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                        state_nxt = PAR;
                        count_nxt = CNT_W'(WIDTH);
                        shreg_nxt = shifted;
`else
                        state_nxt = IDLE;
                        count_nxt = '0;
                        shreg_nxt = '0;
                        word_done = 1'b1;
`endif
                    end else begin
                        count_nxt = count + CNT_W'(1);
                        shreg_nxt = shifted;
                    end
                end
`ifdef PARITY_CHECK_EN
                PAR: begin
                    // Data word is already complete in shreg; sin is the even-parity bit.
                    word      = shreg;
                    state_nxt = IDLE;
                    count_nxt = '0;
                    shreg_nxt = '0;
                    if ((^shreg ^ sin) == 1'b0)
                        word_done = 1'b1;
                    else
                        par_fail = 1'b1;
                end
`endif
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            shreg <= shreg_nxt;
        end
    end

    // Output buffer: a completing word loads only if the slot is free or being handed off now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (word_done && buf_free) begin
                d_out     <= word;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (word_done && !buf_free)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par_err <= 1'b0;
        else if (par_fail)
            par_err <= 1'b1;
        else if (ovr_clr)
            par_err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_serial_byte_loader.sv
// Bench for serial_byte_loader: MSB-first and LSB-first instances on shared stimulus,
// checked against a bit-queue reference model; directed steps then random traffic.
module tb_serial_byte_loader;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst, sin, sin_valid, sync, out_ready, ovr_clr;
    logic [W-1:0] d_out_m, d_out_l;
    logic valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
`ifdef PARITY_CHECK_EN
    logic perr_m, perr_l;
`endif

    always #5 clk = ~clk;

    serial_byte_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sync(sync),
        .out_ready(out_ready), .ovr_clr(ovr_clr), .d_out(d_out_m),
        .out_valid(valid_m), .busy(busy_m),
`ifdef PARITY_CHECK_EN
        .par_err(perr_m),
`endif
        .overrun(ovr_m)
    );

    serial_byte_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sync(sync),
        .out_ready(out_ready), .ovr_clr(ovr_clr), .d_out(d_out_l),
        .out_valid(valid_l), .busy(busy_l),
`ifdef PARITY_CHECK_EN
        .par_err(perr_l),
`endif
        .overrun(ovr_l)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: received bits of the current word, in arrival order.
    bit       mq[$];
    logic [W-1:0] m_dout_m, m_dout_l;
    logic     m_valid, m_ovr, m_perr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_dout_m = '0;
        m_dout_l = '0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_perr   = 1'b0;
    endfunction

    function automatic void model_edge(input logic s, input logic v, input logic sy,
                                       input logic r, input logic c);
        logic free, done, pfail;
        bit   p;
        logic [W-1:0] wm, wl;
        free  = !m_valid || r;
        done  = 1'b0;
        pfail = 1'b0;
        wm    = '0;
        wl    = '0;
        if (sy) mq.delete();
        if (v) mq.push_back(s);
`ifdef PARITY_CHECK_EN
        if (mq.size() == W + 1) begin
            p = 1'b0;
            foreach (mq[i]) p ^= mq[i];
            if (p == 1'b0) done = 1'b1;
            else pfail = 1'b1;
        end
`else
        if (mq.size() == W) done = 1'b1;
`endif
        if (done) begin
            for (int i = 0; i < W; i++) begin
                wm[W-1-i] = mq[i];
                wl[i]     = mq[i];
            end
        end
        if (done || pfail) mq.delete();
        if (done && !free) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
        if (pfail) m_perr = 1'b1;
        else if (c) m_perr = 1'b0;
        if (done && free) begin
            m_dout_m = wm;
            m_dout_l = wl;
            m_valid  = 1'b1;
        end else if (r) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic compare_all(input string where);
        chk({where, ".dout_m"},  d_out_m, m_dout_m);
        chk({where, ".dout_l"},  d_out_l, m_dout_l);
        chk({where, ".valid_m"}, valid_m, m_valid);
        chk({where, ".valid_l"}, valid_l, m_valid);
        chk({where, ".busy_m"},  busy_m,  mq.size() != 0);
        chk({where, ".busy_l"},  busy_l,  mq.size() != 0);
        chk({where, ".ovr_m"},   ovr_m,   m_ovr);
        chk({where, ".ovr_l"},   ovr_l,   m_ovr);
`ifdef PARITY_CHECK_EN
        chk({where, ".perr_m"},  perr_m,  m_perr);
        chk({where, ".perr_l"},  perr_l,  m_perr);
`endif
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic step(input logic s, input logic v, input logic sy, input logic r, input logic c);
        sin       = s;
        sin_valid = v;
        sync      = sy;
        out_ready = r;
        ovr_clr   = c;
        model_edge(s, v, sy, r, c);
        @(posedge clk);
        #1;
        compare_all("step");
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic r, input int gap_at,
                             input int gap_len, input logic first_sync, input logic bad_par);
        for (int i = 0; i < W; i++) begin
            if (i == gap_at) repeat (gap_len) step(1'b0, 1'b0, 1'b0, r, 1'b0);
            step(w[W-1-i], 1'b1, (i == 0) && first_sync, r, 1'b0);
        end
`ifdef PARITY_CHECK_EN
        step((^w) ^ bad_par, 1'b1, 1'b0, r, 1'b0);
`endif
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("async_rst");
        chk("async_rst.dout_zero", d_out_m, 8'h00);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0;
        model_reset();
        #3;
        compare_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stream 0000_1111: MSB-first sees 8'h0F, LSB-first sees 8'hF0; valid for one cycle.
        send_word(8'h0F, 1'b1, -1, 0, 1'b0, 1'b0);
        chk("t1.dout_m", d_out_m, 8'h0F);
        chk("t1.dout_l", d_out_l, 8'hF0);
        chk("t1.valid",  valid_m, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1.valid_drop", valid_m, 1'b0);

        // Three-cycle sin_valid gap between bits 4 and 5.
        send_word(8'h0F, 1'b1, 4, 3, 1'b0, 1'b0);
        chk("t2.dout_l", d_out_l, 8'hF0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Full buffer: second word dropped, overrun set, then handoff and clear.
        send_word(8'hA5, 1'b0, -1, 0, 1'b0, 1'b0);
        send_word(8'h3C, 1'b0, -1, 0, 1'b0, 1'b0);
        chk("t3.dout_hold", d_out_m, 8'hA5);
        chk("t3.overrun",   ovr_m,   1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3.valid_clr", valid_m, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3.ovr_clr", ovr_m, 1'b0);

        // sync restart mid-word, then sync without data mid-word.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'hC3, 1'b1, -1, 0, 1'b1, 1'b0);
        chk("t4.dout_m", d_out_m, 8'hC3);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4.busy_sync", busy_m, 1'b0);

        // Asynchronous reset mid-word, then a clean word.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        async_reset();
        chk("t5.busy",  busy_m,  1'b0);
        chk("t5.valid", valid_m, 1'b0);
        send_word(8'h5A, 1'b1, -1, 0, 1'b0, 1'b0);
        chk("t5.dout_m", d_out_m, 8'h5A);

`ifdef PARITY_CHECK_EN
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'hA5, 1'b1, -1, 0, 1'b0, 1'b0);
        chk("t6.par_ok", d_out_m, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'hA5, 1'b1, -1, 0, 1'b0, 1'b1);
        chk("t6.par_err", perr_m,  1'b1);
        chk("t6.no_valid", valid_m, 1'b0);
`endif

        // Random traffic with occasional sync, stalls, clears and asynchronous resets.
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0);
            if (n % 151 == 150) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
